// File: rtl/oam_pkg.sv
// ---------------------------------------------------------------------------
// oam_pkg
// Shared types and constants for the OAM bus arbiter.
//   owner_t      : which requester owns the current OAM transaction
//   state_t      : transaction FSM states
//   OAM_BYTES    : implemented OAM bytes; higher addresses are unmapped
//   OAM_OPEN_BUS : value returned for unmapped or blocked reads
//   REQ_*        : bit positions of each requester in request/winner vectors
// ---------------------------------------------------------------------------
package oam_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DMA,
    OWN_PPU,
    OWN_CPU
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam int         OAM_BYTES    = 160;
  localparam logic [7:0] OAM_OPEN_BUS = 8'hFF;

  localparam int REQ_CPU = 0;
  localparam int REQ_PPU = 1;
  localparam int REQ_DMA = 2;

  // Converts a one-hot winner vector into the owner encoding.
  function automatic owner_t win_to_owner(input logic [2:0] win);
    owner_t own;
    own = OWN_NONE;
    if (win[REQ_DMA]) begin
      own = OWN_DMA;
    end else if (win[REQ_PPU]) begin
      own = OWN_PPU;
    end else if (win[REQ_CPU]) begin
      own = OWN_CPU;
    end
    return own;
  endfunction

endpackage

// File: rtl/oam_prio_sel.sv
// ---------------------------------------------------------------------------
// oam_prio_sel
// Combinational priority selector for the OAM port.
// Ports:
//   i_req       [2:0] : requests, indexed by REQ_DMA / REQ_PPU / REQ_CPU
//   i_cpu_aged        : CPU has lost enough arbitrations to outrank the PPU
//   i_cpu_block       : CPU may not enter arbitration this cycle
//   o_winner    [2:0] : one-hot winner (all zero when nobody requests)
// Order is DMA > PPU > CPU, or DMA > CPU > PPU while the CPU is aged.
// ---------------------------------------------------------------------------
module oam_prio_sel
  import oam_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic       i_cpu_aged,
  input  logic       i_cpu_block,
  output logic [2:0] o_winner
);

  logic w_cpu_eligible;

  assign w_cpu_eligible = i_req[REQ_CPU] & ~i_cpu_block;

  always_comb begin
    o_winner = '0;
    if (i_req[REQ_DMA]) begin
      o_winner[REQ_DMA] = 1'b1;
    end else if (w_cpu_eligible && i_cpu_aged) begin
      o_winner[REQ_CPU] = 1'b1;
    end else if (i_req[REQ_PPU]) begin
      o_winner[REQ_PPU] = 1'b1;
    end else if (w_cpu_eligible) begin
      o_winner[REQ_CPU] = 1'b1;
    end
  end

endmodule

// File: rtl/oam_bus_arbiter.sv
// ---------------------------------------------------------------------------
// oam_bus_arbiter
// Shares the single OAM port between the DMA engine (writes), the PPU
// (reads) and the CPU (reads/writes). Each access is a 2-cycle ADDR/DATA
// transaction; arbitration happens in IDLE and in DATA so back-to-back
// accesses run at one per 2 clocks.
// Ports:
//   clk1, nreset                : clock, asynchronous active-low reset
//   dma_req/addr/wdata          : DMA write request  -> dma_gnt, dma_done
//   ppu_req/addr, ppu_mode23    : PPU read request   -> ppu_gnt, ppu_done, ppu_rdata
//   cpu_req/we/addr/wdata       : CPU request        -> cpu_gnt, cpu_done, cpu_rdata
//   oam_addr/wdata/we/re, oam_rdata : OAM macro port (rdata one cycle after re)
//   busy                        : transaction FSM not idle
// A request still high in the cycle its done pulses is taken as the next
// request (this is what lets a streaming requester run without bubbles).
// Build option: OAM_CPU_BLOCK_EN - while dma_req or ppu_mode23 is high the
// CPU never arbitrates; its request is answered next cycle with open-bus
// data and no OAM access.
// ---------------------------------------------------------------------------
module oam_bus_arbiter
  import oam_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int OAM_BYTES   = 160,
  parameter int CPU_AGE_MAX = 4
) (
  input  logic              clk1,
  input  logic              nreset,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic              ppu_mode23,
  output logic              ppu_gnt,
  output logic              ppu_done,
  output logic [7:0]        ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              oam_we,
  output logic              oam_re,
  input  logic [7:0]        oam_rdata,
  output logic              busy
);

  localparam int AGE_W = $clog2(CPU_AGE_MAX + 1);

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_we;
  logic [AGE_W-1:0]  r_cpu_age;
  logic [7:0]        r_ppu_rdata;
  logic [7:0]        r_cpu_rdata;
  logic              r_cpu_blk_done;

  logic       w_active;
  logic       w_addr_ph;
  logic       w_data_ph;
  logic       w_arb;
  logic       w_mapped;
  logic       w_cpu_aged;
  logic       w_cpu_block;
  logic       w_blk_fire;
  logic       w_win_any;
  logic [2:0] w_req;
  logic [2:0] w_win;
  logic [7:0] w_rd_val;

  assign w_active   = (r_state != ST_IDLE);
  assign w_addr_ph  = (r_state == ST_ADDR);
  assign w_data_ph  = (r_state == ST_DATA);
  assign w_arb      = (r_state == ST_IDLE) || w_data_ph;
  assign w_mapped   = (32'(r_addr) < 32'(OAM_BYTES));
  assign w_cpu_aged = (r_cpu_age == AGE_W'(CPU_AGE_MAX));

`ifdef OAM_CPU_BLOCK_EN
  // r_cpu_blk_done also keeps the CPU out of arbitration during its
  // early-done cycle, so a still-high req there cannot start an access.
  assign w_cpu_block = dma_req | ppu_mode23 | r_cpu_blk_done;
  assign w_blk_fire  = cpu_req & (dma_req | ppu_mode23) & ~r_cpu_blk_done
                       & ~(w_active && (r_owner == OWN_CPU));
`else
  logic w_unused_mode23;
  assign w_unused_mode23 = ppu_mode23;
  assign w_cpu_block     = 1'b0;
  assign w_blk_fire      = 1'b0;
`endif

  assign w_req     = {dma_req, ppu_req, cpu_req} & {3{w_arb}};
  assign w_win_any = |w_win;

  oam_prio_sel u_prio_sel (
    .i_req       (w_req),
    .i_cpu_aged  (w_cpu_aged),
    .i_cpu_block (w_cpu_block),
    .o_winner    (w_win)
  );

  // Transaction FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_win_any) w_state_next = ST_ADDR;
      ST_ADDR: w_state_next = ST_DATA;
      ST_DATA: w_state_next = w_win_any ? ST_ADDR : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Owner and request snapshot, taken when a winner is chosen.
  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_win_any) begin
      r_owner <= win_to_owner(w_win);
      if (w_win[REQ_DMA]) begin
        r_addr  <= dma_addr;
        r_wdata <= dma_wdata;
        r_we    <= 1'b1;
      end else if (w_win[REQ_PPU]) begin
        r_addr  <= ppu_addr;
        r_wdata <= '0;
        r_we    <= 1'b0;
      end else begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_we    <= cpu_we;
      end
    end else if (w_data_ph) begin
      r_owner <= OWN_NONE;
    end
  end

  // CPU aging: counts arbitrations lost while the CPU keeps requesting.
  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_cpu_age <= '0;
    end else if (!cpu_req || w_cpu_block || w_win[REQ_CPU]) begin
      r_cpu_age <= '0;
    end else if (w_win_any && !w_cpu_aged) begin
      r_cpu_age <= r_cpu_age + AGE_W'(1);
    end
  end

  // Read data registers; unmapped reads return open bus.
  assign w_rd_val = w_mapped ? oam_rdata : OAM_OPEN_BUS;

  always_ff @(posedge clk1 or negedge nreset) begin
    if (!nreset) begin
      r_ppu_rdata    <= OAM_OPEN_BUS;
      r_cpu_rdata    <= OAM_OPEN_BUS;
      r_cpu_blk_done <= 1'b0;
    end else begin
      r_cpu_blk_done <= w_blk_fire;
      if (w_data_ph && (r_owner == OWN_PPU)) begin
        r_ppu_rdata <= w_rd_val;
      end
      if (w_data_ph && (r_owner == OWN_CPU) && !r_we) begin
        r_cpu_rdata <= w_rd_val;
      end else if (w_blk_fire && !cpu_we) begin
        r_cpu_rdata <= OAM_OPEN_BUS;
      end
    end
  end

  // Outputs
  assign busy     = w_active;
  assign dma_gnt  = w_active && (r_owner == OWN_DMA);
  assign ppu_gnt  = w_active && (r_owner == OWN_PPU);
  assign cpu_gnt  = w_active && (r_owner == OWN_CPU);
  assign dma_done = w_data_ph && (r_owner == OWN_DMA);
  assign ppu_done = w_data_ph && (r_owner == OWN_PPU);
  assign cpu_done = (w_data_ph && (r_owner == OWN_CPU)) || r_cpu_blk_done;

  // Read data is forwarded during DATA so it is valid alongside done.
  assign ppu_rdata = ppu_done ? w_rd_val : r_ppu_rdata;
  assign cpu_rdata = (w_data_ph && (r_owner == OWN_CPU) && !r_we) ? w_rd_val : r_cpu_rdata;

  assign oam_addr  = w_addr_ph ? r_addr : '0;
  assign oam_wdata = (w_addr_ph && r_we) ? r_wdata : 8'h00;
  assign oam_we    = w_addr_ph && r_we && w_mapped;
  assign oam_re    = w_addr_ph && !r_we && w_mapped;

endmodule

// File: doc/oam_bus_arbiter.md
Name: oam_bus_arbiter

Overview:
- Sequences every access to the 160-byte sprite attribute memory (OAM) and shares its single port between three requesters.
- Requesters: the DMA engine (page copy into OAM), the PPU (sprite scan and sprite fetch) and the CPU.
- Sits between the DMA/PPU/CPU blocks and the OAM macro.
- Owns the OAM address/strobe mux, the transaction FSM and CPU anti-starvation aging.

Parameters:
- ADDR_W, 8, width of every OAM address bus.
- OAM_BYTES, 160, number of implemented bytes; addresses >= OAM_BYTES are unmapped.
- CPU_AGE_MAX, 4, lost arbitrations after which a pending CPU request outranks the PPU.

Ports:
- clk1 in 1: system clock; all state changes on its rising edge.
- nreset in 1: asynchronous, active-low reset.
- dma_req in 1: DMA write request.
- dma_addr in ADDR_W: DMA target address.
- dma_wdata in 8: DMA write data.
- dma_gnt out 1: DMA granted; high for the full transaction.
- dma_done out 1: one-cycle pulse, DMA write complete.
- ppu_req in 1: PPU read request.
- ppu_addr in ADDR_W: PPU read address.
- ppu_mode23 in 1: PPU is in mode 2 or mode 3.
- ppu_gnt out 1: PPU granted.
- ppu_done out 1: one-cycle pulse, ppu_rdata valid.
- ppu_rdata out 8: PPU read data.
- cpu_req in 1: CPU request.
- cpu_we in 1: CPU request is a write.
- cpu_addr in ADDR_W: CPU address.
- cpu_wdata in 8: CPU write data.
- cpu_gnt out 1: CPU granted.
- cpu_done out 1: one-cycle pulse, CPU access complete.
- cpu_rdata out 8: CPU read data.
- oam_addr out ADDR_W: OAM address.
- oam_wdata out 8: OAM write data.
- oam_we out 1: OAM write strobe.
- oam_re out 1: OAM read strobe.
- oam_rdata in 8: OAM read data, valid the cycle after oam_re.
- busy out 1: FSM is not IDLE.

Behaviour:
- Reset (nreset low, asynchronous): FSM to IDLE, cpu_age to 0, all outputs 0 except cpu_rdata = ppu_rdata = 8'hFF.
- FSM states:
  - IDLE: arbitrate; on a winner, latch the owner and go to ADDR.
  - ADDR: drive oam_addr; oam_we (writes) or oam_re (reads) high for exactly this cycle; go to DATA.
  - DATA: capture oam_rdata into the owner's rdata register; pulse the owner's done; re-arbitrate. On a new winner go to ADDR (back-to-back, no idle bubble); otherwise go to IDLE.
- Latency: 2 clocks from grant to done. Sustained throughput is one access per 2 clocks.
- Grant:
  - The gnt output asserts the cycle the FSM enters ADDR and holds through DATA.
  - Only one gnt is ever high at a time.
  - Requesters hold req, addr and wdata stable until done.
- Priority: DMA > PPU > CPU, except when cpu_age == CPU_AGE_MAX, where the order is DMA > CPU > PPU.
- cpu_age:
  - Saturating counter.
  - Increments at each arbitration won by another requester while cpu_req is high.
  - Clears on CPU grant or when cpu_req is low.
- Unmapped address (addr >= OAM_BYTES):
  - The transaction runs the normal 2-cycle timing with no oam_we/oam_re.
  - Read data returns 8'hFF; writes are dropped.
- A req dropped mid-transaction does not abort it; done still pulses. This is a protocol error, flagged by the bench.
- Reset asserted mid-transaction aborts it with no done pulse.
- rdata registers hold their value until the next read by the same owner.

Optional Feature:
- Macro: OAM_CPU_BLOCK_EN.
- Defined (hardware-accurate blocking):
  - While dma_req or ppu_mode23 is high, the CPU never enters arbitration.
  - cpu_req instead gets cpu_done the next cycle with cpu_rdata = 8'hFF; writes are dropped.
  - No OAM strobe is issued and no cycles are stolen from DMA/PPU.
  - cpu_age is held at 0.
- Undefined: a blocked CPU waits, pending, as described under Behaviour.

Decomposition:
- Shared package oam_pkg:
  - Owner enum {OWN_NONE, OWN_DMA, OWN_PPU, OWN_CPU}.
  - FSM state enum {ST_IDLE, ST_ADDR, ST_DATA}.
  - Constants OAM_BYTES = 160 and OAM_OPEN_BUS = 8'hFF.
- One sub-module: oam_prio_sel. It is purely combinational: req vector + cpu_age saturation flag + block condition -> one-hot winner. The FSM, aging counter and datapath mux stay in the top.

Test Plan:
- Reset mid-ADDR of a CPU write -> oam_we drops immediately; no cpu_done; after release busy = 0 and cpu_rdata = 8'hFF.
- DMA streams 160 writes to addr 0x00..0x9F, data = addr ^ 8'h5A -> 160 dma_done pulses, 2 clocks apart; OAM model matches; no idle cycles.
- ppu_req and cpu_req (read 0x10) in the same cycle -> PPU granted first; CPU granted in the DATA cycle of the PPU access; cpu_done 4 clocks after request.
- ppu_req held continuously, cpu_req pending, CPU_AGE_MAX = 4 -> CPU granted at the 5th arbitration. DMA requesting at that point still wins over the CPU.
- CPU read addr 0xA5 -> 2-cycle access, no oam_re, cpu_rdata = 8'hFF. Write to 0xA5 -> OAM unchanged.
- OAM_CPU_BLOCK_EN defined, ppu_mode23 = 1, CPU write 0x20 <- 8'h33 -> cpu_done next cycle, no oam_we, OAM[0x20] unchanged. With the macro undefined, the same stimulus waits, then writes 8'h33.
